// File: rtl/mbist_pkg.sv
// Shared types and the March C- element table for the memory BIST sequencer.
package mbist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        E0 = 3'd0,
        E1 = 3'd1,
        E2 = 3'd2,
        E3 = 3'd3,
        E4 = 3'd4,
        E5 = 3'd5
    } elem_t;

    localparam logic BG_ZERO = 1'b0;
    localparam logic BG_ONE  = 1'b1;

    // op0 is always issued; op1 only when two_ops is set
    typedef struct packed {
        logic two_ops;
        logic down;
        logic op0_wr;
        logic op0_bg;
        logic op1_wr;
        logic op1_bg;
    } elem_desc_t;

    localparam elem_desc_t [5:0] ELEM_TABLE = {
        elem_desc_t'{1'b0, 1'b0, 1'b0, BG_ZERO, 1'b0, BG_ZERO},  // E5 up   (r0)
        elem_desc_t'{1'b1, 1'b1, 1'b0, BG_ONE,  1'b1, BG_ZERO},  // E4 down (r1, w0)
        elem_desc_t'{1'b1, 1'b1, 1'b0, BG_ZERO, 1'b1, BG_ONE },  // E3 down (r0, w1)
        elem_desc_t'{1'b1, 1'b0, 1'b0, BG_ONE,  1'b1, BG_ZERO},  // E2 up   (r1, w0)
        elem_desc_t'{1'b1, 1'b0, 1'b0, BG_ZERO, 1'b1, BG_ONE },  // E1 up   (r0, w1)
        elem_desc_t'{1'b0, 1'b0, 1'b1, BG_ZERO, 1'b0, BG_ZERO}   // E0 up   (w0)
    };

    function automatic elem_desc_t elem_desc(input elem_t e);
        return (e > E5) ? ELEM_TABLE[0] : ELEM_TABLE[e];
    endfunction

endpackage

// File: rtl/mbist_addr_gen.sv
// Loadable up/down address counter; 'last' flags the terminal address of the current sweep.
module mbist_addr_gen #(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              load_down,
    input  logic              step,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    logic [ADDR_W-1:0] addr_reg;
    logic              down_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_reg <= '0;
            down_reg <= 1'b0;
        end else if (load) begin
            down_reg <= load_down;
            addr_reg <= load_down ? {ADDR_W{1'b1}} : {ADDR_W{1'b0}};
        end else if (step) begin
            addr_reg <= down_reg ? addr_reg - 1'b1 : addr_reg + 1'b1;
        end
    end

    assign addr = addr_reg;
    assign last = down_reg ? (addr_reg == {ADDR_W{1'b0}}) : (addr_reg == {ADDR_W{1'b1}});

endmodule

// File: rtl/mbist_march_ctrl.sv
// March C- sequencer: one SRAM op per RUN cycle, one-stage read compare, sticky fail capture.
module mbist_march_ctrl
    import mbist_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [2:0]        fail_elem,
    output logic [7:0]        fail_count
);

    state_t            state_reg, state_next;
    elem_t             elem_reg, elem_next;
    logic              op_idx_reg;
    elem_desc_t        desc, next_desc;
    logic              cur_wr, cur_bg, last_op;
    logic [ADDR_W-1:0] ag_addr;
    logic              ag_last, ag_load, ag_load_down, ag_step;
    logic              start_run, run_adv, elem_end, final_op;

    logic              cmp_valid_reg;
    logic [DATA_W-1:0] cmp_exp_reg;
    logic [ADDR_W-1:0] cmp_addr_reg;
    elem_t             cmp_elem_reg;
    logic              miscompare;

    logic              fail_reg;
    logic [ADDR_W-1:0] fail_addr_reg;
    logic [2:0]        fail_elem_reg;
    logic [7:0]        fail_count_reg;

    assign desc      = elem_desc(elem_reg);
    assign elem_next = elem_t'(elem_reg + 3'd1);
    assign next_desc = elem_desc(elem_next);
    assign cur_wr    = op_idx_reg ? desc.op1_wr : desc.op0_wr;
    assign cur_bg    = op_idx_reg ? desc.op1_bg : desc.op0_bg;
    assign last_op   = !desc.two_ops || op_idx_reg;

    assign start_run = ((state_reg == ST_IDLE) || (state_reg == ST_DONE)) && start;
    assign run_adv   = (state_reg == ST_RUN) && !abort;
    assign elem_end  = last_op && ag_last;
    assign final_op  = elem_end && (elem_reg == E5);

    // Element boundaries reload the counter rather than relying on wrap-around
    assign ag_load      = start_run || (run_adv && elem_end && (elem_reg != E5));
    assign ag_load_down = start_run ? 1'b0 : next_desc.down;
    assign ag_step      = run_adv && last_op && !ag_last;

    mbist_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (ag_load),
        .load_down (ag_load_down),
        .step      (ag_step),
        .addr      (ag_addr),
        .last      (ag_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= ST_IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE, ST_DONE: if (start) state_next = ST_RUN;
            ST_RUN: begin
                if (abort)         state_next = ST_IDLE;
                else if (final_op) state_next = ST_DRAIN;
            end
            ST_DRAIN: state_next = abort ? ST_IDLE : ST_DONE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        busy      = (state_reg == ST_RUN) || (state_reg == ST_DRAIN);
        done      = (state_reg == ST_DONE);
        if (state_reg == ST_RUN) begin
            mem_en   = 1'b1;
            mem_we   = cur_wr;
            mem_addr = ag_addr;
            if (cur_wr) mem_wdata = {DATA_W{cur_bg}};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            elem_reg      <= E0;
            op_idx_reg    <= 1'b0;
            cmp_valid_reg <= 1'b0;
            cmp_exp_reg   <= '0;
            cmp_addr_reg  <= '0;
            cmp_elem_reg  <= E0;
        end else if (start_run) begin
            elem_reg      <= E0;
            op_idx_reg    <= 1'b0;
            cmp_valid_reg <= 1'b0;
        end else if (run_adv) begin
            op_idx_reg    <= !last_op;
            if (elem_end && (elem_reg != E5)) elem_reg <= elem_next;
            cmp_valid_reg <= !cur_wr;
            cmp_exp_reg   <= {DATA_W{cur_bg}};
            cmp_addr_reg  <= ag_addr;
            cmp_elem_reg  <= elem_reg;
        end else begin
            cmp_valid_reg <= 1'b0;
        end
    end

    // Abort discards the compare that would otherwise land this cycle
    assign miscompare = cmp_valid_reg && !abort && (mem_rdata != cmp_exp_reg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_reg       <= 1'b0;
            fail_addr_reg  <= '0;
            fail_elem_reg  <= '0;
            fail_count_reg <= '0;
        end else if (start_run) begin
            fail_reg       <= 1'b0;
            fail_addr_reg  <= '0;
            fail_elem_reg  <= '0;
            fail_count_reg <= '0;
        end else if (miscompare) begin
            if (fail_count_reg != 8'hFF) fail_count_reg <= fail_count_reg + 8'd1;
            if (!fail_reg) begin
                fail_reg      <= 1'b1;
                fail_addr_reg <= cmp_addr_reg;
                fail_elem_reg <= cmp_elem_reg;
            end
        end
    end

    assign fail       = fail_reg;
    assign fail_addr  = fail_addr_reg;
    assign fail_elem  = fail_elem_reg;
    assign fail_count = fail_count_reg;

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Directed bench: fault-injecting SRAM model, March C- trace check, abort/reset/saturation cases.
module tb_mbist_march_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0, abort = 1'b0;
    logic       mem_en, mem_we, busy, done, fail;
    logic [3:0] mem_addr, fail_addr;
    logic [7:0] mem_wdata, mem_rdata, fail_count;
    logic [2:0] fail_elem;

    logic       start_b = 1'b0;
    logic       abort_b = 1'b0;
    logic       mem_en_b, mem_we_b, busy_b, done_b, fail_b;
    logic [5:0] mem_addr_b, fail_addr_b;
    logic [7:0] mem_wdata_b, fail_count_b;
    logic [7:0] mem_rdata_b = 8'h5A;
    logic [2:0] fail_elem_b;

    logic [7:0] mem [16];
    logic [7:0] sa1 [16];
    logic [7:0] sa0 [16];
    logic [13:0] exp_q [$];
    int n_checks = 0;
    int n_fail = 0;
    int bad_acc = 0;

    always #5 clk = ~clk;

    mbist_march_ctrl #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy), .done(done), .fail(fail),
        .fail_addr(fail_addr), .fail_elem(fail_elem), .fail_count(fail_count)
    );

    mbist_march_ctrl #(.ADDR_W(6), .DATA_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
        .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
        .mem_rdata(mem_rdata_b), .busy(busy_b), .done(done_b), .fail(fail_b),
        .fail_addr(fail_addr_b), .fail_elem(fail_elem_b), .fail_count(fail_count_b)
    );

    // Synchronous single-port SRAM with per-word stuck-at masks on the read path
    always @(posedge clk) begin
        if (!rst_n && mem_en) bad_acc <= bad_acc + 1;
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= (mem[mem_addr] | sa1[mem_addr]) & ~sa0[mem_addr];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    task automatic clear_faults();
        for (int i = 0; i < 16; i++) begin
            sa1[i] = 8'h00;
            sa0[i] = 8'h00;
        end
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    // Entered on the negedge of the first RUN cycle; returns on the first negedge with busy low
    task automatic run_to_done(input bit do_trace);
        int n = 0;
        while (busy && n < 2000) begin
            if (do_trace && n < exp_q.size())
                check_eq($sformatf("trace[%0d]", n), {18'd0, mem_en, mem_we, mem_addr, mem_wdata},
                         {18'd0, exp_q[n]});
            n++;
            @(negedge clk);
        end
        check_eq("busy_len", n, 161);
        check_eq("done", {31'd0, done}, 32'd1);
    endtask

    initial begin
        int nops [6] = '{1, 2, 2, 2, 2, 1};
        int down [6] = '{0, 0, 0, 1, 1, 0};
        bit we0 [6]  = '{1, 0, 0, 0, 0, 0};
        bit bg0 [6]  = '{0, 0, 1, 0, 1, 0};
        bit bg1 [6]  = '{0, 1, 0, 1, 0, 0};
        int n;

        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        clear_faults();
        for (int e = 0; e < 6; e++)
            for (int k = 0; k < 16; k++) begin
                logic [3:0] a;
                a = (down[e] != 0) ? 4'(15 - k) : 4'(k);
                exp_q.push_back({1'b1, we0[e], a, we0[e] ? {8{bg0[e]}} : 8'h00});
                if (nops[e] == 2) exp_q.push_back({1'b1, 1'b1, a, {8{bg1[e]}}});
            end
        exp_q.push_back(14'd0);

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_outputs", {busy, done, fail, mem_en, mem_we, fail_elem, fail_addr, fail_count, mem_addr},
                 32'd0);
        rst_n = 1'b1;

        // Fault-free run with full access trace
        pulse_start();
        check_eq("first_op", {18'd0, mem_en, mem_we, mem_addr, mem_wdata}, {18'd0, 14'h3000});
        run_to_done(1'b1);
        check_eq("ff_fail", {31'd0, fail}, 32'd0);
        check_eq("ff_count", fail_count, 32'd0);

        // Stuck-at-1 bit 3 @5, started from DONE
        sa1[5] = 8'h08;
        pulse_start();
        run_to_done(1'b0);
        check_eq("sa1_fail", {31'd0, fail}, 32'd1);
        check_eq("sa1_addr", fail_addr, 32'd5);
        check_eq("sa1_elem", fail_elem, 32'd1);
        check_eq("sa1_count", fail_count, 32'd3);

        // Stuck-at-0 bit 0 @15 plus stuck-at-1 @2
        clear_faults();
        sa0[15] = 8'h01;
        sa1[2]  = 8'h08;
        pulse_start();
        run_to_done(1'b0);
        check_eq("two_addr", fail_addr, 32'd2);
        check_eq("two_elem", fail_elem, 32'd1);
        check_eq("two_count", fail_count, 32'd5);

        // Abort at RUN cycle 40 (E1 address 12); the @2 miscompare is already recorded
        pulse_start();
        repeat (40) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_eq("abort_state", {29'd0, mem_en, busy, done}, 32'd0);
        check_eq("abort_held", {20'd0, fail, fail_addr, fail_count[6:0]}, {20'd0, 1'b1, 4'd2, 7'd1});
        pulse_start();
        check_eq("restart_op", {18'd0, mem_en, mem_we, mem_addr, mem_wdata}, {18'd0, 14'h3000});
        check_eq("restart_clr", {22'd0, fail, fail_count, fail_elem}, 32'd0);
        run_to_done(1'b1);
        check_eq("restart_count", fail_count, 32'd5);

        // Asynchronous reset at RUN cycle 100
        pulse_start();
        repeat (100) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_mid", {busy, done, fail, mem_en, mem_we, fail_elem, fail_addr, fail_count, mem_addr,
                             5'd0}, 32'd0);
        check_eq("rst_mid_wdata", mem_wdata, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        repeat (5) begin
            @(negedge clk);
            n += int'(mem_en) + int'(busy);
        end
        check_eq("rst_idle", n, 0);
        check_eq("rst_no_access", bad_acc, 0);

        // Every word reads 0x5A: 320 miscompares saturate at 255; start during busy ignored
        @(negedge clk); start_b = 1'b1;
        @(negedge clk); start_b = 1'b0;
        n = 0;
        while (busy_b && n < 5000) begin
            if (n == 50) start_b = 1'b1;
            if (n == 52) start_b = 1'b0;
            n++;
            @(negedge clk);
        end
        check_eq("sat_busy_len", n, 641);
        check_eq("sat_count", fail_count_b, 32'd255);
        check_eq("sat_first", {fail_b, fail_elem_b, fail_addr_b}, {1'b1, 3'd1, 6'd0});
        check_eq("sat_done", {31'd0, done_b}, 32'd1);
        start_b = 1'b1;
        @(negedge clk); start_b = 1'b0;
        check_eq("sat_restart", {21'd0, busy_b, done_b, fail_b, fail_count_b}, {21'd0, 3'b100, 8'd0});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mbist_march_ctrl.md
Name: mbist_march_ctrl

Overview:
- Sequencer for the on-chip test memory in the MBIST/MBISR top.
- On `start`, runs a March C- algorithm over every address of a single-port synchronous SRAM, driving its enable, write-enable, address and data pins.
- Compares read data against the expected background and reports pass/fail, the first failing address and element, and a fail count.
- Its fail outputs feed the MBISR repair logic and the uo_out status pins.

Parameters:
- ADDR_W, 4, memory address width; N = 2**ADDR_W words.
- DATA_W, 8, memory word width; backgrounds are all-0 and all-1 of DATA_W.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  level; sampled only in IDLE or DONE; begins a run.
- abort  in  1  level; stops a run in progress.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  1 = write, 0 = read (valid when mem_en=1).
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  write data.
- mem_rdata  in  DATA_W  read data, valid exactly 1 cycle after a read strobe.
- busy  out  1  run in progress.
- done  out  1  run completed; held until next start.
- fail  out  1  sticky; at least one miscompare this run.
- fail_addr  out  ADDR_W  address of the first miscompare.
- fail_elem  out  3  march element (0-5) of the first miscompare.
- fail_count  out  8  miscompare count, saturates at 255.

Behaviour:
- Reset (async, rst_n=0):
  - All outputs are 0; FSM goes to IDLE.
  - The compare pipeline is cleared.
  - Reset mid-run abandons the run with no memory access after reset asserts.
- States: IDLE, RUN, DRAIN, DONE.
- Start:
  - IDLE or DONE with start=1 at an edge → RUN next cycle.
  - On entry to RUN: busy=1, done=0, and fail/fail_addr/fail_elem/fail_count are cleared.
  - start while busy is ignored.
- Elements (index, direction, ops):
  - E0 up (w0)
  - E1 up (r0, w1)
  - E2 up (r1, w0)
  - E3 down (r0, w1)
  - E4 down (r1, w0)
  - E5 up (r0)
- Up runs 0..N-1; down runs N-1..0.
- Op timing:
  - Exactly one memory op per RUN cycle, with no idle cycles between ops or elements.
  - Multi-op elements complete all ops at one address before moving to the next address.
  - Total RUN length is 10N cycles (160 for ADDR_W=4).
- Write ops: mem_en=1, mem_we=1, mem_wdata = background (0 → all-0, 1 → all-1).
- Read ops:
  - mem_en=1, mem_we=0; mem_wdata is don't-care and is driven 0.
  - Expected data, address and element are registered into a one-stage compare pipeline.
  - Compare happens the following cycle against mem_rdata.
- On miscompare:
  - fail_count increments, saturating at 255.
  - If fail was 0: fail_addr/fail_elem capture the pipelined address/element and fail←1.
  - Later miscompares do not overwrite fail_addr/fail_elem.
- After the last op (E5 read at address N-1): DRAIN for one cycle with mem_en=0 and the final compare performed, then DONE.
- busy is high for exactly 10N+1 cycles.
- DONE: busy=0, done=1, results held stable; mem_en=0.
- abort=1 in RUN or DRAIN:
  - Next cycle goes to IDLE with mem_en=0, busy=0, done=0.
  - The in-flight compare is discarded.
  - Fail results accumulated so far are held.
  - abort in IDLE/DONE has no effect; abort has priority over start.
- mem_en=0 in IDLE, DRAIN and DONE.
- Address counter wrap is never observable: element transitions reload the counter explicitly.

Decomposition:
- Package mbist_pkg:
  - FSM state enum.
  - March element enum E0..E5.
  - Per-element op table constant: op count, directions, read/write + background per op.
  - Constants for background values.
- One sub-module, mbist_addr_gen:
  - Loadable up/down address counter with `last` terminal flag.
  - Controlled by mbist_march_ctrl.

Test Plan:
- Fault-free memory model, start pulse → 160 RUN + 1 DRAIN cycles of busy, done=1, fail=0, fail_count=0; access trace matches the March C- sequence exactly (first op w addr0 data 0x00, last op r addr15 expect 0x00).
- Stuck-at-1 on bit 3 of addr 5 → first miscompare in E0-following read E1 r0 @5; fail=1, fail_addr=5, fail_elem=1, fail_count=3 (E1, E3, E5 reads of 0).
- Stuck-at-0 on bit 0 of addr 15 plus stuck-at-1 at addr 2 → fail_addr=2, fail_elem=1 (first occurrence kept), fail_count=5.
- abort asserted at RUN cycle 40 → mem_en=0 the next cycle, busy=0, done=0; a subsequent start restarts from E0 addr0 with results cleared.
- rst_n dropped at RUN cycle 100 → all outputs 0 immediately; after release with start held low, FSM remains IDLE and mem_en stays 0.
- Memory with every word failing (returns 0x5A always) → fail_count saturates at 255 with no wrap; start re-asserted during busy is ignored; start in DONE begins a new run.
